sub_27bits_seq: RTL and testbench
=================================

SUB_27BITS_SEQ -- requirements
Module: sub_27bits_seq

Interface
REQ-001 SHALL have no parameters; width fixed at 27 bits, chunk width fixed at 9 bits.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_data_one  input  27  minuend.
REQ-005 i_data_two  input  27  subtrahend.
REQ-006 i_borrow  input  1  borrow-in.
REQ-007 i_valid  input  1  operands valid this cycle.
REQ-008 o_ready  output  1  block can accept operands.
REQ-009 o_data  output  27  difference, i_data_one - i_data_two - i_borrow mod 2^27.
REQ-010 o_borrow  output  1  borrow-out; 1 iff i_data_one < i_data_two + i_borrow (unsigned).
REQ-011 o_valid  output  1  o_data/o_borrow hold a completed result.
REQ-012 i_ready  input  1  downstream consumes result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; exactly one state active.
REQ-014 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-015 Accept: i_valid && o_ready at a rising edge; SHALL capture i_data_one, i_data_two, i_borrow into internal registers, clear chunk counter to 0, go IDLE->CALC.
REQ-016 i_valid while not in IDLE SHALL be ignored; operands not captured.
REQ-017 CALC SHALL process one 9-bit chunk per cycle: count 0 bits [8:0], count 1 bits [17:9], count 2 bits [26:18].
REQ-018 Each chunk SHALL subtract with the running borrow: count 0 uses captured i_borrow; counts 1 and 2 use borrow-out of previous chunk.
REQ-019 Chunk result SHALL be written into an internal accumulation register, not to o_data.
REQ-020 At the edge completing count 2: SHALL load o_data from accumulated chunks, o_borrow from chunk-2 borrow-out, go CALC->DONE.
REQ-021 Latency: accept at edge N, o_valid=1 after edge N+3.
REQ-022 DONE: o_valid, o_data, o_borrow SHALL stay stable while i_ready=0, for any number of cycles.
REQ-023 DONE with i_ready=1 at an edge: SHALL go to IDLE, o_valid falls after that edge; o_data/o_borrow keep last value until next DONE load.
REQ-024 No accept in the same cycle as DONE->IDLE; minimum issue interval is 5 cycles.
REQ-025 Chunk counter SHALL reach 2 only in CALC and never wrap within one operation; counter value outside CALC is don't-care but SHALL be 0 after reset.
REQ-026 Arithmetic SHALL be exact for all 2^55 operand/borrow combinations, including borrow propagating across both chunk boundaries.

Reset
REQ-027 i_rst_n=0 SHALL immediately, without a clock edge, force state IDLE, o_ready=1, o_valid=0, o_data=0, o_borrow=0, counter=0, internal operand and accumulation registers=0.
REQ-028 Reset during CALC or DONE SHALL discard the in-flight operation; no partial result appears.
REQ-029 After i_rst_n rises, first accept SHALL be possible at the first rising edge with i_valid=1.

Verification
REQ-030 5 - 3, borrow 0, i_ready=1 -> o_data=27'h0000002, o_borrow=0, o_valid high exactly 3 edges after accept, for one cycle.
REQ-031 0 - 1, borrow 0 -> o_data=27'h7FFFFFF, o_borrow=1.
REQ-032 27'h7FFFFFF - 27'h7FFFFFF, borrow 1 -> o_data=27'h7FFFFFF, o_borrow=1.
REQ-033 Cross-chunk borrow: 27'h0040000 - 27'h0000001, borrow 0 -> o_data=27'h003FFFF, o_borrow=0; also 27'h0000200 - 27'h0000001 -> 27'h00001FF.
REQ-034 Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid with new operands -> o_valid, o_data, o_borrow unchanged, o_ready=0, new operands never captured; i_ready=1 -> IDLE next edge.
REQ-035 Reset pulse asynchronously during CALC count 1 -> all outputs to reset values before next edge; after release, 100 - 40 borrow 0 -> o_data=60, o_borrow=0.

Source files
------------

// File: rtl/sub_27bits_seq.sv
// Multi-cycle 27-bit subtractor: a - b - borrow is computed as three 9-bit chunks,
// one chunk per clock, with a valid/ready handshake on the input and on the output.
module sub_27bits_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [26:0] i_data_one,
  input  logic [26:0] i_data_two,
  input  logic        i_borrow,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [26:0] o_data,
  output logic        o_borrow,
  output logic        o_valid,
  input  logic        i_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [26:0] op_one, op_two, acc;
  logic        borrow_run;
  logic [1:0]  cnt;
  logic [8:0]  chunk_one, chunk_two;
  logic [9:0]  chunk_diff;
  logic        accept, last_chunk;

  assign accept     = i_valid && o_ready;
  assign last_chunk = (cnt == 2'd2);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    chunk_one = op_one[8:0];
    chunk_two = op_two[8:0];
    case (cnt)
      2'd1:    begin chunk_one = op_one[17:9];  chunk_two = op_two[17:9];  end
      2'd2:    begin chunk_one = op_one[26:18]; chunk_two = op_two[26:18]; end
      default: ;
    endcase
    // Bit 9 of the widened difference is the chunk's borrow-out.
    chunk_diff = {1'b0, chunk_one} - {1'b0, chunk_two} - {9'd0, borrow_run};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = CALC;
      end
      CALC: if (last_chunk) state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves no partial result visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_one     <= '0;
      op_two     <= '0;
      borrow_run <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      o_data     <= '0;
      o_borrow   <= 1'b0;
    end else if (accept) begin
      op_one     <= i_data_one;
      op_two     <= i_data_two;
      borrow_run <= i_borrow;
      cnt        <= '0;
    end else if (state == CALC) begin
      borrow_run <= chunk_diff[9];
      case (cnt)
        2'd0:    acc[8:0]   <= chunk_diff[8:0];
        2'd1:    acc[17:9]  <= chunk_diff[8:0];
        default: acc[26:18] <= chunk_diff[8:0];
      endcase
      if (last_chunk) begin
        o_data   <= {chunk_diff[8:0], acc[17:0]};
        o_borrow <= chunk_diff[9];
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sub_27bits_seq.sv
// Scoreboard bench for sub_27bits_seq: stimulus pushes model results, a negedge
// monitor compares each presented result, its latency and its stability.
module tb_sub_27bits_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [26:0] i_data_one = '0, i_data_two = '0;
  logic        i_borrow = 1'b0, i_valid = 1'b0, i_ready;
  logic        o_ready, o_borrow, o_valid;
  logic [26:0] o_data;

  sub_27bits_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_one(i_data_one), .i_data_two(i_data_two),
    .i_borrow(i_borrow), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
    .o_borrow(o_borrow), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [26:0] data;
    logic        borrow;
    int          acc_cyc;
  } exp_t;

  typedef enum int {RDY_ONE, RDY_ZERO, RDY_RAND} rdy_mode_t;

  exp_t      sb[$];
  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  rdy_mode_t rdy_mode = RDY_ONE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole 27-bit operands.
  function automatic exp_t model(input logic [26:0] a, input logic [26:0] b, input logic bin);
    longint unsigned la = a, lb = b, lbin = bin;
    longint unsigned m = 64'd1 << 27;
    exp_t e;
    e.data    = 27'((la + m - lb - lbin) % m);
    e.borrow  = (la < lb + lbin);
    e.acc_cyc = 0;
    return e;
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        RDY_ONE:  i_ready = 1'b1;
        RDY_ZERO: i_ready = 1'b0;
        default:  i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: inputs change only just after posedge, so negedge sees a stable cycle.
  bit prev_valid = 0, after_hs = 0;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_valid = 0;
      after_hs   = 0;
    end else begin
      if (after_hs) check("valid_drop_after_handshake", o_valid, 0);
      after_hs = 0;
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got o_valid=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - sb[0].acc_cyc), 64'd3);
          check("o_data", o_data, sb[0].data);
          check("o_borrow", o_borrow, sb[0].borrow);
          check("o_ready_in_done", o_ready, 0);
          if (i_ready) begin
            void'(sb.pop_front());
            after_hs = 1;
          end
        end
      end
      prev_valid = o_valid;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic issue(input logic [26:0] a, input logic [26:0] b, input logic bin);
    exp_t e;
    int   waited = 0;
    while (!o_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!o_ready) begin
      check("issue_timeout_o_ready", o_ready, 1);
      return;
    end
    i_data_one = a;
    i_data_two = b;
    i_borrow   = bin;
    i_valid    = 1'b1;
    step();
    e = model(a, b, bin);
    e.acc_cyc = cyc;
    sb.push_back(e);
    i_valid    = 1'b0;
    i_data_one = 27'($urandom);
    i_data_two = 27'($urandom);
    i_borrow   = 1'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      step();
      waited++;
    end
    check("drain_empty", 64'(sb.size()), 0);
  endtask

  function automatic logic [26:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 27'(1 << (9 * $urandom_range(0, 2)));
      3:       return 27'($urandom_range(0, 511));
      default: return 27'($urandom);
    endcase
  endfunction

  initial begin
    #3;
    check("rst_o_ready", o_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_borrow", o_borrow, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    issue(27'd5, 27'd3, 1'b0);
    drain();
    issue(27'd0, 27'd1, 1'b0);
    issue(27'h7FFFFFF, 27'h7FFFFFF, 1'b1);
    issue(27'h0040000, 27'h0000001, 1'b0);
    issue(27'h0000200, 27'h0000001, 1'b0);
    issue(27'h0000000, 27'h0000000, 1'b1);
    drain();

    // Backpressure: result held while new operands are offered and must be ignored.
    rdy_mode = RDY_ZERO;
    issue(27'h1234567, 27'h0ABCDEF, 1'b1);
    for (int i = 0; i < 10 && !o_valid; i++) step();
    check("bp_valid_reached", o_valid, 1);
    for (int i = 0; i < 5; i++) begin
      i_valid    = 1'b1;
      i_data_one = 27'($urandom);
      i_data_two = 27'($urandom);
      step();
      check("bp_o_ready", o_ready, 0);
      check("bp_o_valid", o_valid, 1);
    end
    i_valid  = 1'b0;
    rdy_mode = RDY_ONE;
    drain();
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset while chunk 1 is being computed.
    issue(27'h7654321, 27'h0123456, 1'b0);
    step();
    i_rst_n = 1'b0;
    #1;
    check("arst_o_ready", o_ready, 1);
    check("arst_o_valid", o_valid, 0);
    check("arst_o_data", o_data, 0);
    check("arst_o_borrow", o_borrow, 0);
    sb.delete();
    #1;
    i_rst_n = 1'b1;
    issue(27'd100, 27'd40, 1'b0);
    drain();

    rdy_mode = RDY_RAND;
    for (int i = 0; i < 60; i++) issue(pick_operand(), pick_operand(), 1'($urandom));
    drain();
    rdy_mode = RDY_ONE;
    for (int i = 0; i < 8; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
